nearest_req_scheduler: RTL and testbench

NEAREST_REQ_SCHEDULER -- requirements
Module: nearest_req_scheduler

---
 rtl/nearest_req_scheduler.sv | 133 +++++++++++++
 tb/tb_nearest_req_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nearest_req_scheduler.sv
// Nearest-request scheduler: grants the set request closest to a home
// pointer (+d before -d), holds it until done or a bounded timeout.
module nearest_req_scheduler #(
   parameter int NUM_REQ     = 8,
   parameter int INDEX_WIDTH = $clog2(NUM_REQ),
   parameter int MAX_HOLD    = 16,
   parameter int COUNT_WIDTH = $clog2(MAX_HOLD)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_REQ-1:0]     req_vector,
   input  logic                   grant_done,
   input  logic                   set_ptr_valid,
   input  logic [INDEX_WIDTH-1:0] set_ptr_index,
   output logic                   grant_valid,
   output logic [INDEX_WIDTH-1:0] grant_index,
   output logic [NUM_REQ-1:0]     grant_onehot,
   output logic                   timeout_pulse,
   output logic [INDEX_WIDTH-1:0] home_ptr
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] HOLD_LAST = COUNT_WIDTH'(MAX_HOLD - 1);

   state_t                 state_q, state_d;
   logic                   grant_valid_q, grant_valid_d;
   logic [INDEX_WIDTH-1:0] grant_index_q, grant_index_d;
   logic [NUM_REQ-1:0]     grant_onehot_q, grant_onehot_d;
   logic                   timeout_pulse_q, timeout_pulse_d;
   logic [INDEX_WIDTH-1:0] home_ptr_q, home_ptr_d;
   logic [COUNT_WIDTH-1:0] hold_count_q, hold_count_d;

   logic [INDEX_WIDTH-1:0] sel_idx;
   logic                   sel_found;

   // Walk outward from home: d=0, +1, -1, +2, -2, ...; first hit wins
   always_comb begin : sel_search
      logic [INDEX_WIDTH-1:0] off;
      logic [INDEX_WIDTH-1:0] idx_p;
      logic [INDEX_WIDTH-1:0] idx_m;
      sel_idx   = '0;
      sel_found = 1'b0;
      off       = '0;
      idx_p     = '0;
      idx_m     = '0;
      for (int k = 0; k <= NUM_REQ / 2; k++) begin
         off   = INDEX_WIDTH'(k);
         idx_p = home_ptr_q + off;
         idx_m = home_ptr_q - off;
         if (!sel_found && req_vector[idx_p]) begin
            sel_idx   = idx_p;
            sel_found = 1'b1;
         end
         if (!sel_found && req_vector[idx_m]) begin
            sel_idx   = idx_m;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      grant_valid_d   = grant_valid_q;
      grant_index_d   = grant_index_q;
      grant_onehot_d  = grant_onehot_q;
      timeout_pulse_d = 1'b0;
      home_ptr_d      = home_ptr_q;
      hold_count_d    = hold_count_q;

      unique case (state_q)
         IDLE: begin
            grant_valid_d  = 1'b0;
            grant_onehot_d = '0;
            if (sel_found) begin
               state_d                 = GRANT;
               grant_valid_d           = 1'b1;
               grant_index_d           = sel_idx;
               grant_onehot_d[sel_idx] = 1'b1;
               hold_count_d            = '0;
            end
         end
         GRANT: begin
            if (grant_done || hold_count_q == HOLD_LAST) begin
               state_d         = IDLE;
               grant_valid_d   = 1'b0;
               grant_onehot_d  = '0;
               timeout_pulse_d = !grant_done;
               home_ptr_d      = grant_index_q;
               hold_count_d    = '0;
            end else begin
               hold_count_d = hold_count_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Explicit pointer load beats the completion/timeout update
      if (set_ptr_valid) begin
         home_ptr_d = set_ptr_index;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q         <= IDLE;
         grant_valid_q   <= 1'b0;
         grant_index_q   <= '0;
         grant_onehot_q  <= '0;
         timeout_pulse_q <= 1'b0;
         home_ptr_q      <= '0;
         hold_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         grant_valid_q   <= grant_valid_d;
         grant_index_q   <= grant_index_d;
         grant_onehot_q  <= grant_onehot_d;
         timeout_pulse_q <= timeout_pulse_d;
         home_ptr_q      <= home_ptr_d;
         hold_count_q    <= hold_count_d;
      end
   end

   assign grant_valid   = grant_valid_q;
   assign grant_index   = grant_index_q;
   assign grant_onehot  = grant_onehot_q;
   assign timeout_pulse = timeout_pulse_q;
   assign home_ptr      = home_ptr_q;

endmodule

// File: tb/tb_nearest_req_scheduler.sv
// Bench for nearest_req_scheduler: directed scenarios plus random traffic
// against a cycle-level behavioural model of the grant rules.
module tb_nearest_req_scheduler;

   localparam int N  = 8;
   localparam int MH = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req_vector;
   logic         grant_done;
   logic         set_ptr_valid;
   logic [2:0]   set_ptr_index;
   logic         grant_valid;
   logic [2:0]   grant_index;
   logic [N-1:0] grant_onehot;
   logic         timeout_pulse;
   logic [2:0]   home_ptr;

   int n_chk  = 0;
   int n_pass = 0;

   int m_busy = 0;
   int m_idx  = 0;
   int m_age  = 0;
   int m_home = 0;
   int m_to   = 0;

   always #5 clk = ~clk;

   nearest_req_scheduler #(
      .NUM_REQ  (N),
      .MAX_HOLD (MH)
   ) dut (
      .CLK           (clk),
      .RST           (rst),
      .req_vector    (req_vector),
      .grant_done    (grant_done),
      .set_ptr_valid (set_ptr_valid),
      .set_ptr_index (set_ptr_index),
      .grant_valid   (grant_valid),
      .grant_index   (grant_index),
      .grant_onehot  (grant_onehot),
      .timeout_pulse (timeout_pulse),
      .home_ptr      (home_ptr)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   // Nearest set bit by circular distance, +d preferred over -d
   function automatic int m_sel(input logic [N-1:0] r, input int h);
      for (int d = 0; d <= N / 2; d++) begin
         if (r[(h + d) % N]) return (h + d) % N;
         if (r[(h - d + N) % N]) return (h - d + N) % N;
      end
      return 0;
   endfunction

   task automatic model_step(input bit r, input logic [N-1:0] rq,
                             input bit dn, input bit sp, input int spi);
      int nh;
      if (r) begin
         m_busy = 0; m_idx = 0; m_age = 0; m_home = 0; m_to = 0;
         return;
      end
      nh   = m_home;
      m_to = 0;
      if (m_busy != 0) begin
         if (dn || m_age == MH - 1) begin
            m_busy = 0;
            nh     = m_idx;
            m_to   = dn ? 0 : 1;
         end else begin
            m_age++;
         end
      end else if (rq != 0) begin
         m_busy = 1;
         m_idx  = m_sel(rq, m_home);
         m_age  = 0;
      end
      if (sp) nh = spi;
      m_home = nh;
   endtask

   task automatic compare_all();
      chk("valid", int'(grant_valid), m_busy);
      chk("home", int'(home_ptr), m_home);
      chk("timeout", int'(timeout_pulse), m_to);
      chk("onehot", int'(grant_onehot), m_busy != 0 ? (1 << m_idx) : 0);
      if (m_busy != 0) chk("index", int'(grant_index), m_idx);
   endtask

   task automatic cycle(input bit r, input logic [N-1:0] rq, input bit dn,
                        input bit sp, input int spi);
      @(negedge clk);
      rst           = r;
      req_vector    = rq;
      grant_done    = dn;
      set_ptr_valid = sp;
      set_ptr_index = 3'(spi);
      model_step(r, rq, dn, sp, spi);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      int cnt;
      rst = 1'b1; req_vector = '0; grant_done = 1'b0;
      set_ptr_valid = 1'b0; set_ptr_index = '0;

      cycle(1, 8'h00, 0, 0, 0);
      cycle(1, 8'h00, 1, 1, 5);
      chk("rst_valid", int'(grant_valid), 0);
      chk("rst_home", int'(home_ptr), 0);
      chk("rst_index", int'(grant_index), 0);

      for (int i = 0; i < 10; i++) begin
         cycle(0, 8'h00, 0, 0, 0);
         chk("idle_valid", int'(grant_valid), 0);
      end
      chk("idle_home", int'(home_ptr), 0);

      cycle(0, 8'b0100_0100, 0, 0, 0);
      chk("tie_index", int'(grant_index), 2);
      chk("tie_onehot", int'(grant_onehot), 'h04);
      cycle(0, 8'h00, 1, 0, 0);

      cycle(0, 8'h00, 0, 1, 3);
      chk("setptr_home", int'(home_ptr), 3);
      cycle(0, 8'b1000_0001, 0, 0, 0);
      chk("near_index", int'(grant_index), 0);
      cycle(0, 8'h00, 1, 0, 0);
      chk("done_valid", int'(grant_valid), 0);
      chk("done_home", int'(home_ptr), 0);

      cycle(0, 8'h00, 0, 1, 5);
      cycle(0, 8'h20, 0, 0, 0);
      chk("to_index", int'(grant_index), 5);
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 8'h00, 0, 0, 0);
         if (!grant_valid) break;
         cnt++;
      end
      chk("to_len", cnt, MH);
      chk("to_pulse", int'(timeout_pulse), 1);
      chk("to_home", int'(home_ptr), 5);
      cycle(0, 8'h00, 0, 0, 0);
      chk("to_pulse_end", int'(timeout_pulse), 0);

      cycle(0, 8'h40, 0, 0, 0);
      chk("g6_index", int'(grant_index), 6);
      cycle(0, 8'h00, 1, 1, 1);
      chk("prio_valid", int'(grant_valid), 0);
      chk("prio_home", int'(home_ptr), 1);

      cycle(0, 8'h01, 0, 0, 0);
      for (int i = 0; i < 7; i++) cycle(0, 8'hff, 0, 0, 0);
      chk("pre_rst_valid", int'(grant_valid), 1);
      cycle(1, 8'h00, 1, 1, 4);
      chk("mid_rst_valid", int'(grant_valid), 0);
      chk("mid_rst_to", int'(timeout_pulse), 0);
      chk("mid_rst_home", int'(home_ptr), 0);
      cycle(0, 8'h80, 0, 0, 0);
      chk("post_rst_index", int'(grant_index), 7);
      chk("post_rst_valid", int'(grant_valid), 1);
      cycle(0, 8'h00, 1, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] rq;
         bit r, dn, sp;
         rq = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         r  = ($urandom_range(0, 199) == 0);
         dn = ($urandom_range(0, 11) == 0);
         sp = ($urandom_range(0, 15) == 0);
         cycle(r, rq, dn, sp, int'($urandom_range(0, N - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
